// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer sizing and per-entry status flags. Imported by the ROB,
// its interface, and anything that carries a rob_addr (e.g. execution_buffer).
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int PHYS_REGS = 64;
    localparam int ROB_AW    = $clog2(ROB_DEPTH);
    localparam int PREG_W    = $clog2(PHYS_REGS);

    typedef struct packed {
        logic valid;
        logic done;
        logic use_rw;
        logic is_branch;
        logic mispredict;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch/execute/commit signal bundle for the reorder buffer.
// master = dispatch+execute side, slave = the ROB itself.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int L         = ROB_DEPTH,
    parameter int NUM_D_REG = PHYS_REGS
);
    localparam int AW = $clog2(L);
    localparam int PW = $clog2(NUM_D_REG);

    logic          alloc_valid;
    logic          alloc_ready;
    logic [AW-1:0] alloc_rob_addr;
    logic          alloc_use_rw;
    logic [PW-1:0] alloc_rw_addr;
    logic [PW-1:0] alloc_prev_rw_addr;
    logic          alloc_is_branch;

    logic          complete_valid;
    logic [AW-1:0] complete_rob_addr;
    logic          complete_mispredict;

    logic          commit_valid;
    logic [AW-1:0] commit_rob_addr;
    logic          commit_use_rw;
    logic [PW-1:0] commit_free_addr;
    logic          flush;
    logic          empty;

    modport master (
        output alloc_valid, alloc_use_rw, alloc_rw_addr, alloc_prev_rw_addr, alloc_is_branch,
        output complete_valid, complete_rob_addr, complete_mispredict,
        input  alloc_ready, alloc_rob_addr,
        input  commit_valid, commit_rob_addr, commit_use_rw, commit_free_addr, flush, empty
    );

    modport slave (
        input  alloc_valid, alloc_use_rw, alloc_rw_addr, alloc_prev_rw_addr, alloc_is_branch,
        input  complete_valid, complete_rob_addr, complete_mispredict,
        output alloc_ready, alloc_rob_addr,
        output commit_valid, commit_rob_addr, commit_use_rw, commit_free_addr, flush, empty
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocate at tail, mark done by index, retire from head.
// A mispredicted branch reaching the head commits and then flushes everything.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int L         = ROB_DEPTH,
    parameter int NUM_D_REG = PHYS_REGS
) (
    input logic            clk,
    input logic            rst,
    reorder_buffer_if.slave rob
);
    localparam int AW = $clog2(L);
    localparam int PW = $clog2(NUM_D_REG);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(L);

    rob_entry_t    entries [L];
    logic [PW-1:0] prev_rw [L];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic alloc_fire;
    logic commit_fire;
    logic flush_now;

    assign commit_fire = entries[head].valid & entries[head].done;
    assign flush_now   = commit_fire & entries[head].mispredict;
    // Registered count only: a commit in the same cycle does not open a slot when full.
    assign alloc_fire  = rob.alloc_valid & (count != FULL_COUNT) & ~flush_now;

    assign rob.alloc_ready      = (count != FULL_COUNT) & ~flush_now;
    assign rob.alloc_rob_addr   = tail;
    assign rob.commit_valid     = commit_fire;
    assign rob.commit_rob_addr  = head;
    assign rob.commit_use_rw    = entries[head].use_rw;
    assign rob.commit_free_addr = prev_rw[head];
    assign rob.flush            = flush_now;
    assign rob.empty            = (count == '0);

    always_ff @(posedge clk) begin
        if (rst || flush_now) begin
            for (int unsigned i = 0; i < L; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (rob.complete_valid && entries[rob.complete_rob_addr].valid) begin
                entries[rob.complete_rob_addr].done       <= 1'b1;
                entries[rob.complete_rob_addr].mispredict <=
                    rob.complete_mispredict & entries[rob.complete_rob_addr].is_branch;
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            // Placed last so a fresh allocation always starts with done = 0.
            if (alloc_fire) begin
                entries[tail] <= '{valid: 1'b1, done: 1'b0, use_rw: rob.alloc_use_rw,
                                   is_branch: rob.alloc_is_branch, mispredict: 1'b0};
                prev_rw[tail] <= rob.alloc_prev_rw_addr;
                tail          <= tail + 1'b1;
            end
            count <= count + {{AW{1'b0}}, alloc_fire} - {{AW{1'b0}}, commit_fire};
        end
    end

endmodule
